alu_serial_seq: RTL
===================

Name: alu_serial_seq

Overview:
Bit-serial sequencer that sits directly upstream and downstream of the 1-bit ALU cell (alu_1bit). It accepts a WIDTH-bit operand pair plus a 3-bit opcode over a valid/ready handshake. It then drives the 1-bit cell LSB-first, one bit per clock, chaining carry/borrow through a register. It collects the result bits into a WIDTH-bit word, presented with a valid/ready handshake. This makes the 1-bit cell usable as an area-minimal 8-bit ALU.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand request valid.
- in_ready, output, 1, block can accept a request; high only in IDLE.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- in_op, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101-111 undefined.
- out_valid, output, 1, result valid; high only in DONE.
- out_ready, input, 1, consumer accepts result.
- out_result, output, WIDTH, assembled result word.
- out_carry, output, 1, final carry-out (ADD) or borrow-out (SUB); 0 for logic and undefined ops.
- alu_a, output, 1, bit to cell input a.
- alu_b, output, 1, bit to cell input b.
- alu_cin, output, 1, to cell input cin.
- alu_op, output, 3, to cell input op.
- alu_result, input, 1, from cell result (combinational in the same cycle).
- alu_cout, input, 1, from cell cout.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, bit counter=0, carry register=0, result register=0, in_ready=1, out_valid=0, out_result=0, out_carry=0, alu_a/alu_b/alu_cin=0, alu_op=3'b000.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a, in_b and in_op.
  - Clear the carry register and bit counter, clear the result register, then go to RUN.
- State RUN (WIDTH cycles, counter i = 0..WIDTH-1):
  - Drive alu_a=a_reg[i], alu_b=b_reg[i], alu_cin=carry_reg and alu_op=op_reg.
  - At each edge, res_reg[i] <= alu_result.
  - carry_reg <= alu_cout when op_reg is 000 or 001; otherwise carry_reg <= 0.
  - When i==WIDTH-1, go to DONE; otherwise i <= i+1.
- State DONE:
  - out_valid=1; out_result=res_reg and out_carry=carry_reg are held stable while out_valid && !out_ready.
  - On out_valid&&out_ready, go to IDLE.
- Cell drive outside RUN: alu_a, alu_b and alu_cin are 0; alu_op is 000.
- Carry semantics: the carry register feeds cin directly for both ADD and SUB. For SUB the cell computes a-b-cin, so cout is a borrow and the initial cin is 0. The final out_carry=1 means unsigned A<B.
- Undefined opcodes: passed to the cell unchanged. The cell returns 0, so out_result=0 and out_carry=0. No error is raised.
- Latency: acceptance edge at T. Bits are processed at edges T+1..T+WIDTH. out_valid is high from cycle T+WIDTH+1.
- Throughput: there is no overlap. The next request is accepted no earlier than one cycle after the result handshake, so the minimum period is WIDTH+2 cycles.
- in_valid in non-IDLE states: ignored; the requester must hold it high (in_ready=0).
- Reset mid-operation: rst in RUN or DONE aborts at the next edge. The partial result is discarded, the block returns to IDLE with reset values, and out_valid is not asserted for the aborted request.
- Counter: width $clog2(WIDTH); it never exceeds WIDTH-1 and wraps to 0 only via IDLE.

Optional Feature:
- Macro: ALU_SERIAL_FLAGS_EN.
- With the macro defined:
  - Adds output out_zero (1 bit), equal to (res_reg==0).
  - Adds output out_neg (1 bit), equal to res_reg[WIDTH-1].
  - Both are registered, valid with out_valid, and reset to 0.
  - out_zero is accumulated during RUN as the AND of ~alu_result. It is not computed from the full word at the end.
- Without the macro: these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- ADD, no overflow: A=8'h5A, B=8'h3C, op=000 → out_result=8'h96, out_carry=0, out_valid exactly 9 cycles after the acceptance edge.
- ADD with wrap: A=8'hFF, B=8'h01, op=000 → out_result=8'h00, out_carry=1 (flags build: out_zero=1, out_neg=0).
- SUB with borrow: A=8'h10, B=8'h20, op=001 → out_result=8'hF0, out_carry=1. SUB without borrow: A=8'h20, B=8'h10 → 8'h10, out_carry=0.
- Logic ops and undefined opcode:
  - AND F0/3C → 8'h30.
  - OR F0/0F → 8'hFF.
  - XOR AA/FF → 8'h55.
  - In all three cases out_carry=0.
  - op=111 → 8'h00, out_carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result and carry stay stable and in_ready stays 0. A new in_valid during that time is not accepted and is taken one cycle after the out handshake.
- Reset mid-run: assert rst at bit 4 of an ADD → next cycle in_ready=1, out_valid=0, all outputs at reset values. The following request 8'h01+8'h01 returns 8'h02.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer wrapping an external 1-bit ALU cell: accepts a WIDTH-bit operand pair,
// walks the cell LSB-first with a carry/borrow register, returns the result word.
// Optional flags outputs (out_zero, out_neg) are enabled by defining ALU_SERIAL_FLAGS_EN.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
`ifdef ALU_SERIAL_FLAGS_EN
  output logic             out_zero,
  output logic             out_neg,
`endif
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       op_q;
  logic             cin_q;
  logic             accept;
  logic             last;
  logic             carry_nx;

  // Operand shifters empty themselves during RUN, so the cell sees 0 outside RUN.
  assign alu_a      = a_sh[0];
  assign alu_b      = b_sh[0];
  assign alu_cin    = cin_q;
  assign alu_op     = op_q;
  assign out_result = res_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    carry_nx = 1'b0;
    case (state)
      S_IDLE: begin
        accept = in_valid;
        if (in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        last     = (cnt == LAST);
        carry_nx = (op_q == 3'b000 || op_q == 3'b001) ? alu_cout : 1'b0;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_q     <= '0;
      op_q      <= 3'b000;
      cin_q     <= 1'b0;
      out_carry <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nx == S_IDLE);
      out_valid <= (state_nx == S_DONE);
      if (accept) begin
        a_sh      <= in_a;
        b_sh      <= in_b;
        op_q      <= in_op;
        res_q     <= '0;
        cnt       <= '0;
        cin_q     <= 1'b0;
        out_carry <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
        out_zero  <= 1'b1;
        out_neg   <= 1'b0;
`endif
      end else if (state == S_RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        res_q <= {alu_result, res_q[WIDTH-1:1]};
`ifdef ALU_SERIAL_FLAGS_EN
        out_zero <= out_zero & ~alu_result;
`endif
        if (last) begin
          // Final carry moves to the output; the cell drive returns to its idle values.
          cnt       <= '0;
          op_q      <= 3'b000;
          cin_q     <= 1'b0;
          out_carry <= carry_nx;
`ifdef ALU_SERIAL_FLAGS_EN
          out_neg   <= alu_result;
`endif
        end else begin
          cnt   <= cnt + CW'(1);
          cin_q <= carry_nx;
        end
      end
    end
  end

endmodule
